// File: rtl/iccm_prog_ctrl.sv
// iccm_prog_ctrl: boot-time ICCM programming controller.
// Assembles little-endian 32-bit words from the UART rx byte stream and writes
// them to sequential ICCM word addresses. Holds the core in programming reset
// until the terminator word arrives, then releases it.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_byte_i/rx_valid_i received UART byte and its one-cycle strobe
//   reprog_i             pulse; restarts programming from DONE
//   iccm_ctrl_addr_o     ICCM word address (AW bits)
//   iccm_ctrl_wdata_o    ICCM write data
//   iccm_ctrl_we_o       ICCM write strobe, one cycle per word
//   prog_rst_no          core programming reset, 0 = hold core
//   done_o               programming complete
//   err_o                sticky error (address overflow / checksum)
//
// Build option: define ICCM_PROG_CKSUM_EN to require a checksum word (XOR of
// all written words) after the terminator.
module iccm_prog_ctrl #(
    parameter int unsigned AW       = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    input  logic          reprog_i,
    output logic [AW-1:0] iccm_ctrl_addr_o,
    output logic [31:0]   iccm_ctrl_wdata_o,
    output logic          iccm_ctrl_we_o,
    output logic          prog_rst_no,
    output logic          done_o,
    output logic          err_o
);

`ifdef ICCM_PROG_CKSUM_EN
    typedef enum logic [1:0] {LOAD, OVF, DONE, CHK} state_t;
`else
    typedef enum logic [1:0] {LOAD, OVF, DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]   idle_q, idle_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          prog_rst_n_q, prog_rst_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    // Set once the top address has been written; the address register then
    // holds instead of wrapping, and the next data word is an overflow.
    logic          top_written_q, top_written_d;
    logic [31:0]   full;
    logic          word_end;
`ifdef ICCM_PROG_CKSUM_EN
    logic [31:0]   cksum_q, cksum_d;
`endif

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        idle_d        = idle_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        prog_rst_n_d  = prog_rst_n_q;
        done_d        = done_q;
        err_d         = err_q;
        top_written_d = top_written_q;
        full          = {rx_byte_i, shift_q[31:8]};
        word_end      = 1'b0;
`ifdef ICCM_PROG_CKSUM_EN
        cksum_d       = cksum_q;
`endif

        // Address advances after the write cycle.
        if (we_q) begin
            if (addr_q == '1) begin
                top_written_d = 1'b1;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end

        // Byte assembly and partial-word timeout; rx is ignored in DONE.
        if (state_q != DONE) begin
            if (rx_valid_i) begin
                shift_d = full;
                idle_d  = '0;
                if (byte_cnt_q == 2'd3) begin
                    byte_cnt_d = '0;
                    word_end   = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end else if (byte_cnt_q != '0) begin
                if (idle_q != TIMEOUT) begin
                    idle_d = idle_q + 16'd1;
                end
                if (idle_d == TIMEOUT) begin
                    byte_cnt_d = '0;
                end
            end
        end

        if (word_end) begin
            case (state_q)
                LOAD, OVF: begin
                    if (full == END_WORD) begin
`ifdef ICCM_PROG_CKSUM_EN
                        state_d = CHK;
`else
                        state_d      = DONE;
                        prog_rst_n_d = 1'b1;
                        done_d       = 1'b1;
`endif
                    end else if (state_q == LOAD) begin
                        if (top_written_q) begin
                            err_d   = 1'b1;
                            state_d = OVF;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = full;
`ifdef ICCM_PROG_CKSUM_EN
                            cksum_d = cksum_q ^ full;
`endif
                        end
                    end
                end
`ifdef ICCM_PROG_CKSUM_EN
                CHK: begin
                    if (full != cksum_q) begin
                        err_d = 1'b1;
                    end
                    state_d      = DONE;
                    prog_rst_n_d = 1'b1;
                    done_d       = 1'b1;
                end
`endif
                default: ;
            endcase
        end

        if (state_q == DONE && reprog_i) begin
            state_d       = LOAD;
            prog_rst_n_d  = 1'b0;
            done_d        = 1'b0;
            err_d         = 1'b0;
            addr_d        = '0;
            byte_cnt_d    = '0;
            idle_d        = '0;
            top_written_d = 1'b0;
`ifdef ICCM_PROG_CKSUM_EN
            cksum_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= LOAD;
            shift_q       <= '0;
            byte_cnt_q    <= '0;
            idle_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            prog_rst_n_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            top_written_q <= 1'b0;
`ifdef ICCM_PROG_CKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_q        <= idle_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            prog_rst_n_q  <= prog_rst_n_d;
            done_q        <= done_d;
            err_q         <= err_d;
            top_written_q <= top_written_d;
`ifdef ICCM_PROG_CKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    assign iccm_ctrl_addr_o  = addr_q;
    assign iccm_ctrl_wdata_o = wdata_q;
    assign iccm_ctrl_we_o    = we_q;
    assign prog_rst_no       = prog_rst_n_q;
    assign done_o            = done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_iccm_prog_ctrl.sv
// tb_iccm_prog_ctrl: self-checking bench for iccm_prog_ctrl.
// Expected writes are queued as words are sent and popped when the DUT
// strobes iccm_ctrl_we_o. Honours ICCM_PROG_CKSUM_EN when defined.
module tb_iccm_prog_ctrl;
    localparam int unsigned AW       = 2;
    localparam int unsigned TMO_CYC  = 20;
    localparam int unsigned ADDR_MAX = (1 << AW) - 1;
    localparam logic [31:0] END_W    = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          reprog;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic          prog_rst_n;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    iccm_prog_ctrl #(
        .AW      (AW),
        .END_WORD(END_W),
        .TIMEOUT (16'(TMO_CYC))
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rx_byte_i        (rx_byte),
        .rx_valid_i       (rx_valid),
        .reprog_i         (reprog),
        .iccm_ctrl_addr_o (addr),
        .iccm_ctrl_wdata_o(wdata),
        .iccm_ctrl_we_o   (we),
        .prog_rst_no      (prog_rst_n),
        .done_o           (done),
        .err_o            (err)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    int unsigned n_wr  = 0;
    int unsigned m_nwr = 0;
    logic [63:0] sb[$];
    int unsigned m_addr = 0;
    bit          m_last = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_xor  = '0;
    logic        prev_we = 1'b0;
`ifdef ICCM_PROG_CKSUM_EN
    logic [31:0] cks_flip = '0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (we) begin
                n_wr++;
                check_eq("we_b2b", 64'(prev_we), 64'd0);
                if (sb.size() == 0) begin
                    check_eq("we_unexp", 64'(we), 64'd0);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check_eq("wr_addr", 64'(addr), {32'd0, e[63:32]});
                    check_eq("wr_data", 64'(wdata), {32'd0, e[31:0]});
                end
            end
            prev_we = we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_last = 1'b0;
        m_err  = 1'b0;
        m_xor  = '0;
    endtask

    // Data word (never END_W); gap idle cycles inserted before the last byte.
    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        bit          wr;
        logic [31:0] t;
        wr = 1'b0;
        t  = w;
        if (m_last) begin
            m_err = 1'b1;
        end else begin
            wr = 1'b1;
            sb.push_back({32'(m_addr), w});
            m_nwr++;
            m_xor = m_xor ^ w;
            if (m_addr == ADDR_MAX) m_last = 1'b1;
            else m_addr++;
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(t[7:0]);
            t = t >> 8;
        end
        idle(gap);
        send_byte(t[7:0]);
        check_eq("we_lat", 64'(we), 64'(wr));
        check_eq("err", 64'(err), 64'(m_err));
    endtask

    task automatic send_end();
        logic [31:0] t;
        t = END_W;
        for (int i = 0; i < 3; i++) begin
            send_byte(t[7:0]);
            t = t >> 8;
        end
        check_eq("rst_hold", 64'(prog_rst_n), 64'd0);
        send_byte(t[7:0]);
        check_eq("end_nowr", 64'(we), 64'd0);
`ifdef ICCM_PROG_CKSUM_EN
        check_eq("chk_wait", 64'(done), 64'd0);
        t = m_xor ^ cks_flip;
        if (cks_flip != '0) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0]);
            t = t >> 8;
        end
`endif
        check_eq("prog_rel", 64'(prog_rst_n), 64'd1);
        check_eq("done", 64'(done), 64'd1);
        check_eq("err_end", 64'(err), 64'(m_err));
    endtask

    task automatic do_reprog();
        reprog = 1'b1;
        @(posedge clk);
        #1;
        reprog = 1'b0;
        model_reset();
        check_eq("rp_prog", 64'(prog_rst_n), 64'd0);
        check_eq("rp_done", 64'(done), 64'd0);
        check_eq("rp_err", 64'(err), 64'd0);
        check_eq("rp_addr", 64'(addr), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"}, 64'(addr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(wdata), 64'd0);
        check_eq({tag, "_we"}, 64'(we), 64'd0);
        check_eq({tag, "_prog"}, 64'(prog_rst_n), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = '0;
        reprog   = 1'b0;
        #12;
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Two words then terminator
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_end();
        check_eq("addr_after2", 64'(addr), 64'd2);
        check_eq("wr_cnt1", 64'(n_wr), 64'd2);

        // Bytes in DONE are ignored
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        idle(2);
        check_eq("done_hold", 64'(done), 64'd1);

        // Partial word dropped after exactly TIMEOUT idle cycles; one fewer keeps it
        do_reprog();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(TMO_CYC);
        send_word(32'h0000_0001, 0);
        send_word(32'h1122_3344, TMO_CYC - 1);
        send_end();

        // Address overflow
        do_reprog();
        for (int unsigned i = 0; i < 5; i++) send_word(32'hC0DE_0000 + i, 0);
        send_word(32'hBAD0_0006, 0);
        send_end();

        // Reprogram window
        do_reprog();
        send_word(32'hA5A5_A5A5, 0);
        send_end();

        // reprog outside DONE ignored, then async reset mid-word
        do_reprog();
        send_word(32'h1111_1111, 0);
        idle(2);
        check_eq("addr_adv", 64'(addr), 64'd1);
        reprog = 1'b1;
        @(posedge clk);
        #1;
        reprog = 1'b0;
        check_eq("rp_ign_addr", 64'(addr), 64'd1);
        check_eq("rp_ign_prog", 64'(prog_rst_n), 64'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        #2;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_eq("sb_flush", 64'(sb.size()), 64'd0);
        send_word(32'h2222_2222, 0);
        send_end();

`ifdef ICCM_PROG_CKSUM_EN
        do_reprog();
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0002, 0);
        send_end();
        do_reprog();
        cks_flip = 32'h0000_0007;
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0002, 0);
        send_end();
        cks_flip = '0;
`endif

        idle(3);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        check_eq("n_writes", 64'(n_wr), 64'(m_nwr));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
